// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: address width, register count,
// FSM state encoding and requester identifiers.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MEM = 1;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requests, clear control and register-file write port of regfile_write_arbiter.
// The arbiter connects through the slave modport; requesters drive through master.
interface regfile_write_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    import regfile_pkg::*;

    logic                  alu_valid_i;
    reg_addr_t             alu_reg_i;
    logic [DATA_WIDTH-1:0] alu_data_i;
    logic                  alu_ready_o;

    logic                  mem_valid_i;
    reg_addr_t             mem_reg_i;
    logic [DATA_WIDTH-1:0] mem_data_i;
    logic                  mem_ready_o;

    logic                  clear_i;
    logic                  clear_busy_o;
    logic                  clear_done_o;

    logic                  Reg_Write_o;
    reg_addr_t             Write_Register_o;
    logic [DATA_WIDTH-1:0] Write_Data_o;

    modport master (
        output alu_valid_i, alu_reg_i, alu_data_i,
        output mem_valid_i, mem_reg_i, mem_data_i,
        output clear_i,
        input  alu_ready_o, mem_ready_o, clear_busy_o, clear_done_o,
        input  Reg_Write_o, Write_Register_o, Write_Data_o
    );

    modport slave (
        input  alu_valid_i, alu_reg_i, alu_data_i,
        input  mem_valid_i, mem_reg_i, mem_data_i,
        input  clear_i,
        output alu_ready_o, mem_ready_o, clear_busy_o, clear_done_o,
        output Reg_Write_o, Write_Register_o, Write_Data_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. On a contested cycle the pointer's requester wins; after any
// grant the pointer moves to the requester that lost.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import regfile_pkg::*;

    logic ptr_q, ptr_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt[ptr_q] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt[REQ_ALU]) begin
            ptr_d = 1'(REQ_MEM);
        end else if (gnt[REQ_MEM]) begin
            ptr_d = 1'(REQ_ALU);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'(REQ_ALU);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register file's write port: arbitrates ALU/MEM writebacks round-robin and runs a
// sequencer that zeroes registers 1..NUM_REGS-1 on command.
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = regfile_pkg::NUM_REGS
) (
    input logic                    clk,
    input logic                    reset,
    regfile_write_arbiter_if.slave wb
);
    import regfile_pkg::*;

    localparam reg_addr_t LAST_REG = REG_ADDR_W'(NUM_REGS - 1);

    logic [0:0]            state_q, state_d;
    reg_addr_t             clr_cnt_q, clr_cnt_d;
    logic                  we_q, we_d;
    reg_addr_t             wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  arb_en;
    logic [1:0]            req, gnt;

    // A clear request in ARB pre-empts both valids for that cycle.
    assign arb_en = !reset && (state_q == ST_ARB) && !wb.clear_i;
    assign req    = {wb.mem_valid_i, wb.alu_valid_i};

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   (req),
        .gnt   (gnt)
    );

    assign wb.alu_ready_o      = gnt[REQ_ALU];
    assign wb.mem_ready_o      = gnt[REQ_MEM];
    assign wb.clear_busy_o     = (state_q == ST_CLEAR);
    assign wb.clear_done_o     = (state_q == ST_CLEAR) && (clr_cnt_q == LAST_REG);
    assign wb.Reg_Write_o      = we_q;
    assign wb.Write_Register_o = wreg_q;
    assign wb.Write_Data_o     = wdata_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        we_d      = 1'b0;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        case (state_q)
            ST_ARB: begin
                if (wb.clear_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (gnt[REQ_ALU]) begin
                    we_d    = (wb.alu_reg_i != REG_ZERO);
                    wreg_d  = wb.alu_reg_i;
                    wdata_d = wb.alu_data_i;
                end else if (gnt[REQ_MEM]) begin
                    we_d    = (wb.mem_reg_i != REG_ZERO);
                    wreg_d  = wb.mem_reg_i;
                    wdata_d = wb.mem_data_i;
                end
            end
            ST_CLEAR: begin
                // The counter holds the register written this cycle; it saturates at LAST_REG.
                if (clr_cnt_q == LAST_REG) begin
                    state_d = ST_ARB;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    we_d      = 1'b1;
                    wreg_d    = clr_cnt_q + 1'b1;
                    wdata_d   = '0;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ARB;
            clr_cnt_q <= '0;
            we_q      <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            we_q      <= we_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus constrained-random traffic, all
// checked against a cycle-level reference model of the write-port behaviour.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int NREGS = 32;

    logic clk = 1'b0;
    logic reset;

    regfile_write_arbiter_if #(.DATA_WIDTH(32)) wb ();

    regfile_write_arbiter #(.DATA_WIDTH(32), .NUM_REGS(NREGS)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: m_clr is the cycle number inside a clear sequence (0 = arbitrating).
    int          m_clr;
    int          m_favour;
    logic        m_we;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    bit          m_known;
    bit          last_alu, last_mem;
    int          grants[$];

    task automatic model_reset();
        m_clr = 0; m_favour = 0; m_we = 1'b0; m_wreg = '0; m_wdata = '0; m_known = 1'b1;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model on the rising edge.
    task automatic step();
        bit e_alu, e_mem;
        e_alu = 1'b0;
        e_mem = 1'b0;
        if (!reset && m_clr == 0 && !wb.clear_i) begin
            if (wb.alu_valid_i && wb.mem_valid_i) begin
                if (m_favour == 0) e_alu = 1'b1;
                else e_mem = 1'b1;
            end else begin
                e_alu = wb.alu_valid_i;
                e_mem = wb.mem_valid_i;
            end
        end
        @(negedge clk);
        check_eq("alu_ready", wb.alu_ready_o, e_alu);
        check_eq("mem_ready", wb.mem_ready_o, e_mem);
        check_eq("clear_busy", wb.clear_busy_o, m_clr != 0);
        check_eq("clear_done", wb.clear_done_o, m_clr == NREGS);
        check_eq("reg_write", wb.Reg_Write_o, m_we);
        if (m_known) begin
            check_eq("write_register", wb.Write_Register_o, m_wreg);
            check_eq("write_data", wb.Write_Data_o, m_wdata);
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (m_clr != 0) begin
            if (m_clr < NREGS) begin
                m_we = 1'b1; m_wreg = 5'(m_clr); m_wdata = '0; m_known = 1'b1;
                m_clr++;
            end else begin
                m_clr = 0; m_we = 1'b0;
            end
        end else if (wb.clear_i) begin
            m_clr = 1; m_we = 1'b0;
        end else if (e_alu || e_mem) begin
            m_wreg   = e_alu ? wb.alu_reg_i : wb.mem_reg_i;
            m_wdata  = e_alu ? wb.alu_data_i : wb.mem_data_i;
            m_we     = (m_wreg != 5'd0);
            m_known  = (m_wreg != 5'd0);
            m_favour = e_alu ? 1 : 0;
            grants.push_back(e_alu ? 0 : 1);
        end else begin
            m_we = 1'b0;
        end
        last_alu = e_alu;
        last_mem = e_mem;
        #1;
    endtask

    task automatic drive_random(input int cycles, input int clr_pm, input int rst_pm);
        for (int i = 0; i < cycles; i++) begin
            if (!wb.alu_valid_i || last_alu) begin
                wb.alu_valid_i = ($urandom_range(99) < 60);
                wb.alu_reg_i   = 5'($urandom_range(31));
                wb.alu_data_i  = $urandom;
            end
            if (!wb.mem_valid_i || last_mem) begin
                wb.mem_valid_i = ($urandom_range(99) < 60);
                wb.mem_reg_i   = 5'($urandom_range(31));
                wb.mem_data_i  = $urandom;
            end
            wb.clear_i = ($urandom_range(999) < clr_pm);
            reset      = ($urandom_range(999) < rst_pm);
            step();
        end
    endtask

    initial begin
        int  n;
        bit  found;
        reset = 1'b1;
        wb.alu_valid_i = 1'b1; wb.alu_reg_i = 5'd9; wb.alu_data_i = 32'h1;
        wb.mem_valid_i = 1'b0; wb.mem_reg_i = '0;   wb.mem_data_i = '0;
        wb.clear_i = 1'b0;
        last_alu = 1'b0; last_mem = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        // Reset with a pending request: ready must stay low.
        step();
        step();

        // Idle after reset.
        reset = 1'b0;
        wb.alu_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Single ALU write.
        wb.alu_valid_i = 1'b1; wb.alu_reg_i = 5'd5; wb.alu_data_i = 32'hDEADBEEF;
        step();
        wb.alu_valid_i = 1'b0;
        check_eq("t2_we", wb.Reg_Write_o, 1);
        check_eq("t2_reg", wb.Write_Register_o, 5);
        check_eq("t2_data", wb.Write_Data_o, 32'hDEADBEEF);
        step();

        // MEM write to reg 0: accepted but not written. Also returns the pointer to ALU.
        wb.mem_valid_i = 1'b1; wb.mem_reg_i = 5'd0; wb.mem_data_i = 32'h1234;
        step();
        wb.mem_valid_i = 1'b0;
        check_eq("t4_we", wb.Reg_Write_o, 0);
        step();

        // Contested requests alternate starting with ALU.
        grants.delete();
        wb.alu_valid_i = 1'b1; wb.alu_reg_i = 5'd3; wb.alu_data_i = 32'hA3;
        wb.mem_valid_i = 1'b1; wb.mem_reg_i = 5'd4; wb.mem_data_i = 32'hB4;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t3_reg", wb.Write_Register_o, (i % 2 == 0) ? 3 : 4);
        end
        wb.alu_valid_i = 1'b0; wb.mem_valid_i = 1'b0;
        check_eq("t3_count", grants.size(), 4);
        if (grants.size() == 4) begin
            for (int i = 0; i < 4; i++) check_eq("t3_order", grants[i], i % 2);
        end
        step();

        // Clear with a waiting ALU request: ALU is served only after the sequence.
        wb.clear_i = 1'b1;
        wb.alu_valid_i = 1'b1; wb.alu_reg_i = 5'd7; wb.alu_data_i = 32'h55;
        n = 0;
        do begin
            step();
            wb.clear_i = 1'b0;
            n++;
        end while (!last_alu && n < 60);
        check_eq("t5_wait_cycles", n, NREGS + 2);
        wb.alu_valid_i = 1'b0;
        check_eq("t5_alu_reg", wb.Write_Register_o, 7);
        check_eq("t5_alu_we", wb.Reg_Write_o, 1);
        step();

        // Reset during the write of reg 10, then a fresh clear restarts at reg 1.
        wb.clear_i = 1'b1;
        step();
        wb.clear_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = wb.Reg_Write_o && (wb.Write_Register_o == 5'd10);
        end
        check_eq("t6_reached_reg10", found, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t6_busy", wb.clear_busy_o, 0);
        check_eq("t6_we", wb.Reg_Write_o, 0);
        check_eq("t6_reg", wb.Write_Register_o, 0);
        wb.clear_i = 1'b1;
        step();
        wb.clear_i = 1'b0;
        step();
        check_eq("t6_restart_reg", wb.Write_Register_o, 1);
        check_eq("t6_restart_we", wb.Reg_Write_o, 1);
        for (int i = 0; i < 35; i++) step();

        // Random traffic with occasional clears and resets.
        drive_random(3000, 6, 3);
        reset = 1'b0; wb.clear_i = 1'b0;
        drive_random(500, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
